// File: rtl/gpio_config_loader_if.sv
// Serial configuration chain and status signals for one GPIO pad loader.
interface gpio_config_loader_if #(
  parameter int unsigned WIDTH = 10
);
  logic             serial_data_in;
  logic             serial_enable;
  logic             serial_load;
  logic             reload;
  logic             serial_data_out;
  logic [WIDTH-1:0] gpio_config;
  logic             cfg_valid;
  logic             load_done;
  logic             busy;
  logic             short_frame;

  modport master (
    output serial_data_in, serial_enable, serial_load, reload,
    input  serial_data_out, gpio_config, cfg_valid, load_done, busy, short_frame
  );

  modport slave (
    input  serial_data_in, serial_enable, serial_load, reload,
    output serial_data_out, gpio_config, cfg_valid, load_done, busy, short_frame
  );
endinterface

// File: rtl/gpio_config_loader.sv
// Per-pad GPIO configuration loader: shifts a config word through a serial
// chain, commits it on serial_load, and falls back to tie-cell defaults on
// reset or reload.
module gpio_config_loader #(
  parameter int unsigned WIDTH = 10
) (
  input  logic                   serial_clock,
  input  logic                   resetn,
  input  logic [WIDTH-1:0]       gpio_defaults,
  gpio_config_loader_if.slave    bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] FULL  = 2'd3;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] shift_q,  shift_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] config_q, config_d;
  logic             valid_q,  valid_d;
  logic             done_q,   done_d;
  logic             short_q,  short_d;

  // Next-state logic: INIT applies defaults, reload beats load, load commits the pre-shift word.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    config_d = config_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    short_d  = short_q;

    if (state_q == INIT) begin
      config_d = gpio_defaults;
      shift_d  = gpio_defaults;
      cnt_d    = '0;
      valid_d  = 1'b1;
      state_d  = IDLE;
    end else if (bus.reload) begin
      config_d = gpio_defaults;
      shift_d  = gpio_defaults;
      cnt_d    = '0;
      short_d  = 1'b0;
      done_d   = 1'b1;
      state_d  = IDLE;
    end else begin
      if (bus.serial_enable) begin
        shift_d = {shift_q[WIDTH-2:0], bus.serial_data_in};
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // The shift above still happens; the commit takes the word as it stood before this edge.
      if (bus.serial_load) begin
        config_d = shift_q;
        cnt_d    = '0;
        short_d  = (cnt_q != CNT_MAX);
        done_d   = 1'b1;
        state_d  = IDLE;
      end else if (bus.serial_enable) begin
        state_d = (cnt_d == CNT_MAX) ? FULL : SHIFT;
      end
    end
  end

  // State registers, cleared asynchronously while resetn is low.
  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= INIT;
      shift_q  <= '0;
      cnt_q    <= '0;
      config_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      config_q <= config_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      short_q  <= short_d;
    end
  end

  assign bus.serial_data_out = shift_q[WIDTH-1];
  assign bus.gpio_config     = config_q;
  assign bus.cfg_valid       = valid_q;
  assign bus.load_done       = done_q;
  assign bus.busy            = (state_q == SHIFT) || (state_q == FULL);
  assign bus.short_frame     = short_q;

endmodule

// File: tb/tb_gpio_config_loader.sv
// Directed self-checking bench for gpio_config_loader.
module tb_gpio_config_loader;

  localparam int unsigned W = 10;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] defaults;
  int           n_checks;
  int           n_errors;

  gpio_config_loader_if #(.WIDTH(W)) bus ();

  gpio_config_loader #(.WIDTH(W)) dut (
    .serial_clock  (clk),
    .resetn        (rst_n),
    .gpio_defaults (defaults),
    .bus           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.serial_data_in = 1'b0;
    bus.serial_enable  = 1'b0;
    bus.serial_load    = 1'b0;
    bus.reload         = 1'b0;
  endtask

  task automatic shift_bits(input logic [W-1:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.serial_enable  = 1'b1;
      bus.serial_data_in = val[i];
      cyc();
    end
    bus.serial_enable  = 1'b0;
    bus.serial_data_in = 1'b0;
  endtask

  task automatic do_load();
    bus.serial_load = 1'b1;
    cyc();
    bus.serial_load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] seen;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    defaults = 10'h155;
    idle_inputs();

    // Reset state, then INIT on first edge with all strobes ignored
    cyc();
    chk("rst_config", 32'(bus.gpio_config), 32'h0);
    chk("rst_valid", 32'(bus.cfg_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_sdo", 32'(bus.serial_data_out), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_config_before_edge", 32'(bus.gpio_config), 32'h0);
    bus.serial_enable  = 1'b1;
    bus.serial_data_in = 1'b1;
    bus.serial_load    = 1'b1;
    bus.reload         = 1'b1;
    cyc();
    idle_inputs();
    chk("init_config", 32'(bus.gpio_config), 32'h155);
    chk("init_valid", 32'(bus.cfg_valid), 32'h1);
    chk("init_busy", 32'(bus.busy), 32'h0);
    chk("init_sdo", 32'(bus.serial_data_out), 32'h0);
    chk("init_load_done", 32'(bus.load_done), 32'h0);
    cyc();
    chk("init_ignored_shift_busy", 32'(bus.busy), 32'h0);

    // Full frame 0x2A5; serial_data_out replays the old 0x155 MSB first
    seen = '0;
    for (int i = W - 1; i >= 0; i--) begin
      seen = {seen[W-2:0], bus.serial_data_out};
      bus.serial_enable  = 1'b1;
      bus.serial_data_in = 1'(10'h2A5 >> i);
      cyc();
    end
    idle_inputs();
    chk("chain_out", 32'(seen), 32'h155);
    chk("full_busy", 32'(bus.busy), 32'h1);
    chk("config_held_while_shifting", 32'(bus.gpio_config), 32'h155);
    do_load();
    chk("full_config", 32'(bus.gpio_config), 32'h2A5);
    chk("full_load_done", 32'(bus.load_done), 32'h1);
    chk("full_short", 32'(bus.short_frame), 32'h0);
    chk("full_busy_after", 32'(bus.busy), 32'h0);
    cyc();
    chk("full_load_done_drop", 32'(bus.load_done), 32'h0);

    // Reload to 0x155, then short frame 1011
    bus.reload = 1'b1;
    cyc();
    bus.reload = 1'b0;
    chk("reload_config", 32'(bus.gpio_config), 32'h155);
    chk("reload_load_done", 32'(bus.load_done), 32'h1);
    shift_bits(10'h00B, 4);
    chk("short_busy", 32'(bus.busy), 32'h1);
    do_load();
    chk("short_config", 32'(bus.gpio_config), 32'h15B);
    chk("short_flag", 32'(bus.short_frame), 32'h1);
    chk("short_idle", 32'(bus.busy), 32'h0);

    // Reload during SHIFT beats simultaneous load and shift
    shift_bits(10'h005, 3);
    bus.reload         = 1'b1;
    bus.serial_load    = 1'b1;
    bus.serial_enable  = 1'b1;
    bus.serial_data_in = 1'b1;
    cyc();
    idle_inputs();
    chk("prio_config", 32'(bus.gpio_config), 32'h155);
    chk("prio_short", 32'(bus.short_frame), 32'h0);
    chk("prio_load_done", 32'(bus.load_done), 32'h1);
    chk("prio_busy", 32'(bus.busy), 32'h0);
    cyc();
    chk("prio_single_pulse", 32'(bus.load_done), 32'h0);
    // 9 bits after reload must count as short: bit counter restarted at 0
    shift_bits(10'h0F0, 9);
    do_load();
    chk("prio_cnt_cleared_config", 32'(bus.gpio_config), 32'h2F0);
    chk("prio_cnt_cleared_short", 32'(bus.short_frame), 32'h1);

    // Full frame 0x3C3, then two back-to-back loads with no shifts
    shift_bits(10'h3C3, 10);
    do_load();
    chk("b2b_setup_short", 32'(bus.short_frame), 32'h0);
    bus.serial_load = 1'b1;
    cyc();
    chk("b2b_first_done", 32'(bus.load_done), 32'h1);
    chk("b2b_first_short", 32'(bus.short_frame), 32'h1);
    cyc();
    bus.serial_load = 1'b0;
    chk("b2b_second_done", 32'(bus.load_done), 32'h1);
    chk("b2b_config", 32'(bus.gpio_config), 32'h3C3);
    cyc();
    chk("b2b_done_drop", 32'(bus.load_done), 32'h0);

    // Asynchronous reset after 6 bits of a frame
    shift_bits(10'h02A, 6);
    chk("mid_busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_config", 32'(bus.gpio_config), 32'h0);
    chk("async_valid", 32'(bus.cfg_valid), 32'h0);
    chk("async_busy", 32'(bus.busy), 32'h0);
    chk("async_short", 32'(bus.short_frame), 32'h0);
    chk("async_sdo", 32'(bus.serial_data_out), 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("async_rel_config", 32'(bus.gpio_config), 32'h0);
    cyc();
    chk("reinit_config", 32'(bus.gpio_config), 32'h155);
    chk("reinit_valid", 32'(bus.cfg_valid), 32'h1);
    chk("reinit_busy", 32'(bus.busy), 32'h0);
    cyc();
    chk("reinit_idle", 32'(bus.busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
